mem_port_arbiter: RTL and testbench

//  Shares the data port (Raddr2/Wdata/Rdata2) of ideal_mem between two masters:
//  m0 = mips_cpu data path, m1 = debug/loader master (program load, result dump).

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/rr_pick2.sv | 16 +
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the ideal_mem data-port arbiter: FSM states and master indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RD_RESP
  } arb_state_t;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_DBG = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one
// that was not granted last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = req[1];
    if (&req) grant = ~last;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the ideal_mem data port between the CPU data path (m0) and the
// debug/loader master (m1), one access in flight, with a contention counter.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-3:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-3:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,

  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic [ADDR_WIDTH-3:0] mem_waddr,
  output logic [ADDR_WIDTH-3:0] mem_raddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,

  output logic [31:0]           conflict_cnt
);

  arb_state_t state;
  logic       sel;
  logic       last_grant;

  logic                  pick;
  logic                  pick_valid;
  logic                  win_we;
  logic [ADDR_WIDTH-3:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  rr_pick2 u_pick (
    .req   ({m1_req, m0_req}),
    .last  (last_grant),
    .grant (pick),
    .valid (pick_valid)
  );

  always_comb begin
    win_we    = (pick == MASTER_DBG) ? m1_we    : m0_we;
    win_addr  = (pick == MASTER_DBG) ? m1_addr  : m0_addr;
    win_wdata = (pick == MASTER_DBG) ? m1_wdata : m0_wdata;
  end

  // Memory strobes and acks are registered alongside the state, so they come
  // up in the same cycle the FSM enters WR/RD/RD_RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= MASTER_CPU;
      last_grant <= MASTER_DBG;
      mem_wren   <= 1'b0;
      mem_rden   <= 1'b0;
      mem_waddr  <= '0;
      mem_raddr  <= '0;
      mem_wdata  <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
    end else begin
      mem_wren  <= 1'b0;
      mem_rden  <= 1'b0;
      mem_waddr <= '0;
      mem_raddr <= '0;
      mem_wdata <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            sel        <= pick;
            last_grant <= pick;
            if (win_we) begin
              state     <= WR;
              mem_wren  <= 1'b1;
              mem_waddr <= win_addr;
              mem_wdata <= win_wdata;
              m0_ack    <= (pick == MASTER_CPU);
              m1_ack    <= (pick == MASTER_DBG);
            end else begin
              state     <= RD;
              mem_rden  <= 1'b1;
              mem_raddr <= win_addr;
            end
          end
        end
        WR: state <= IDLE;
        RD: begin
          state  <= RD_RESP;
          m0_ack <= (sel == MASTER_CPU);
          m1_ack <= (sel == MASTER_DBG);
        end
        RD_RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data arrives from ideal_mem during RD_RESP, so it is steered straight through.
  always_comb begin
    m0_rdata = '0;
    m1_rdata = '0;
    if (state == RD_RESP) begin
      if (sel == MASTER_DBG) m1_rdata = mem_rdata;
      else                   m0_rdata = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      conflict_cnt <= '0;
    else if (state == IDLE && m0_req && m1_req)
      conflict_cnt <= conflict_cnt + 32'd1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small ideal_mem model on the data port.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_WIDTH = 11;
  localparam int DATA_WIDTH = 32;
  localparam int AW         = ADDR_WIDTH - 2;

  logic                  clk;
  logic                  rst_n;
  logic                  m0_req, m0_we, m0_ack;
  logic [AW-1:0]         m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata, m0_rdata;
  logic                  m1_req, m1_we, m1_ack;
  logic [AW-1:0]         m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata, m1_rdata;
  logic                  mem_wren, mem_rden;
  logic [AW-1:0]         mem_waddr, mem_raddr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
  logic [31:0]           conflict_cnt;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  logic [DATA_WIDTH-1:0] tb_mem  [0:(1<<AW)-1];
  logic                  written [0:(1<<AW)-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_req       (m0_req),
    .m0_we        (m0_we),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_ack       (m0_ack),
    .m0_rdata     (m0_rdata),
    .m1_req       (m1_req),
    .m1_we        (m1_we),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_ack       (m1_ack),
    .m1_rdata     (m1_rdata),
    .mem_wren     (mem_wren),
    .mem_rden     (mem_rden),
    .mem_waddr    (mem_waddr),
    .mem_raddr    (mem_raddr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .conflict_cnt (conflict_cnt)
  );

  // Unwritten words read back as 0xC0DE0000 | word address.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < (1<<AW); i++) written[i] <= 1'b0;
      mem_rdata <= '0;
    end else begin
      if (mem_wren) begin
        tb_mem[mem_waddr]  <= mem_wdata;
        written[mem_waddr] <= 1'b1;
      end
      if (mem_rden)
        mem_rdata <= written[mem_raddr] ? tb_mem[mem_raddr]
                                        : (32'hC0DE_0000 | 32'(mem_raddr));
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (!mem_wren) begin
        checks++;
        assert (mem_waddr === '0) else begin
          failures++;
          $error("[TB] FAIL waddr_zero observed=%h expected=0", mem_waddr);
        end
      end
      if (!mem_rden) begin
        checks++;
        assert (mem_raddr === '0) else begin
          failures++;
          $error("[TB] FAIL raddr_zero observed=%h expected=0", mem_raddr);
        end
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic master, input logic req, input logic we,
                                input logic [AW-1:0] addr, input logic [DATA_WIDTH-1:0] wdata);
    if (master == MASTER_DBG) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int n_acks;
    int last_idx;
    int idx;

    apply_stimulus(MASTER_CPU, 1'b0, 1'b0, '0, '0);
    apply_stimulus(MASTER_DBG, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    tick(); tick();
    check_output("rst_state",      32'(dut.state), 32'(IDLE));
    check_output("rst_last_grant", 32'(dut.last_grant), 32'd1);
    check_output("rst_m0_ack",     32'(m0_ack), 32'd0);
    check_output("rst_m1_ack",     32'(m1_ack), 32'd0);
    check_output("rst_wren",       32'(mem_wren), 32'd0);
    check_output("rst_rden",       32'(mem_rden), 32'd0);
    check_output("rst_wdata",      mem_wdata, 32'd0);
    check_output("rst_m0_rdata",   m0_rdata, 32'd0);
    check_output("rst_conflict",   conflict_cnt, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    $display("[TB] m0 write then read-back");
    apply_stimulus(MASTER_CPU, 1'b1, 1'b1, 9'h010, 32'hDEAD_BEEF);
    tick();
    check_output("wr_wren",   32'(mem_wren), 32'd1);
    check_output("wr_waddr",  32'(mem_waddr), 32'h010);
    check_output("wr_wdata",  mem_wdata, 32'hDEAD_BEEF);
    check_output("wr_m0_ack", 32'(m0_ack), 32'd1);
    check_output("wr_m1_ack", 32'(m1_ack), 32'd0);
    apply_stimulus(MASTER_CPU, 1'b0, 1'b0, '0, '0);
    tick();
    check_output("wr_done_ack",   32'(m0_ack), 32'd0);
    check_output("wr_done_state", 32'(dut.state), 32'(IDLE));
    apply_stimulus(MASTER_CPU, 1'b1, 1'b0, 9'h010, '0);
    tick();
    check_output("rd_rden",   32'(mem_rden), 32'd1);
    check_output("rd_raddr",  32'(mem_raddr), 32'h010);
    check_output("rd_early_ack", 32'(m0_ack), 32'd0);
    tick();
    check_output("rd_m0_ack",   32'(m0_ack), 32'd1);
    check_output("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    check_output("rd_m1_rdata", m1_rdata, 32'd0);
    apply_stimulus(MASTER_CPU, 1'b0, 1'b0, '0, '0);
    tick();
    check_output("rd_done_rdata", m0_rdata, 32'd0);

    $display("[TB] simultaneous reads from reset");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_output("tie_rst_conflict", conflict_cnt, 32'd0);
    apply_stimulus(MASTER_CPU, 1'b1, 1'b0, 9'h020, '0);
    apply_stimulus(MASTER_DBG, 1'b1, 1'b0, 9'h1FF, '0);
    tick();
    check_output("tie_rd_m0_raddr", 32'(mem_raddr), 32'h020);
    check_output("tie_conflict1",   conflict_cnt, 32'd1);
    tick();
    check_output("tie_m0_ack",   32'(m0_ack), 32'd1);
    check_output("tie_m1_wait",  32'(m1_ack), 32'd0);
    check_output("tie_m0_rdata", m0_rdata, 32'hC0DE_0020);
    apply_stimulus(MASTER_CPU, 1'b0, 1'b0, '0, '0);
    tick();
    check_output("tie_n3_m1_ack", 32'(m1_ack), 32'd0);
    tick();
    check_output("tie_m1_raddr_max", 32'(mem_raddr), 32'h1FF);
    tick();
    check_output("tie_m1_ack",   32'(m1_ack), 32'd1);
    check_output("tie_m1_rdata", m1_rdata, 32'hC0DE_01FF);
    check_output("tie_m0_quiet", m0_rdata, 32'd0);
    check_output("tie_conflict_final", conflict_cnt, 32'd1);
    apply_stimulus(MASTER_DBG, 1'b0, 1'b0, '0, '0);
    tick();

    $display("[TB] held contention alternates grants");
    apply_stimulus(MASTER_CPU, 1'b1, 1'b1, 9'h005, 32'h1111_1111);
    apply_stimulus(MASTER_DBG, 1'b1, 1'b1, 9'h006, 32'h2222_2222);
    n_acks   = 0;
    last_idx = -1;
    for (int cyc = 0; cyc < 20 && n_acks < 4; cyc++) begin
      tick();
      if (m0_ack || m1_ack) begin
        idx = m1_ack ? 1 : 0;
        check_output("rr_grant", 32'(idx), 32'(n_acks % 2));
        check_output("rr_waddr", 32'(mem_waddr), (idx == 1) ? 32'h006 : 32'h005);
        if (last_idx >= 0) check_output("rr_no_repeat", 32'(idx != last_idx), 32'd1);
        last_idx = idx;
        n_acks++;
        if (n_acks == 4) begin
          apply_stimulus(MASTER_CPU, 1'b0, 1'b0, '0, '0);
          apply_stimulus(MASTER_DBG, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    check_output("rr_ack_count", 32'(n_acks), 32'd4);
    apply_stimulus(MASTER_CPU, 1'b0, 1'b0, '0, '0);
    apply_stimulus(MASTER_DBG, 1'b0, 1'b0, '0, '0);
    tick();
    check_output("rr_conflict", conflict_cnt, 32'd5);

    $display("[TB] reset during read");
    apply_stimulus(MASTER_CPU, 1'b1, 1'b0, 9'h030, '0);
    tick();
    check_output("abort_rden", 32'(mem_rden), 32'd1);
    rst_n = 1'b0;
    apply_stimulus(MASTER_CPU, 1'b0, 1'b0, '0, '0);
    tick();
    check_output("abort_ack",      32'(m0_ack), 32'd0);
    check_output("abort_rden_off", 32'(mem_rden), 32'd0);
    check_output("abort_state",    32'(dut.state), 32'(IDLE));
    check_output("abort_conflict", conflict_cnt, 32'd0);
    rst_n = 1'b1;
    tick();
    check_output("abort_no_late_ack", 32'(m0_ack), 32'd0);

    $display("[TB] contention counter wrap");
    force dut.conflict_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.conflict_cnt;
    check_output("wrap_preload", conflict_cnt, 32'hFFFF_FFFF);
    apply_stimulus(MASTER_CPU, 1'b1, 1'b0, 9'h040, '0);
    apply_stimulus(MASTER_DBG, 1'b1, 1'b0, 9'h041, '0);
    tick();
    check_output("wrap_zero",  conflict_cnt, 32'd0);
    check_output("wrap_raddr", 32'(mem_raddr), 32'h040);
    apply_stimulus(MASTER_CPU, 1'b0, 1'b0, '0, '0);
    apply_stimulus(MASTER_DBG, 1'b0, 1'b0, '0, '0);
    tick();
    check_output("wrap_m0_ack",   32'(m0_ack), 32'd1);
    check_output("wrap_m0_rdata", m0_rdata, 32'hC0DE_0040);
    tick();
    check_output("wrap_hold", conflict_cnt, 32'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
